// File: rtl/score_display.sv
// score_display: serial double-dabble score display with level readout and high-score tracking.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros on hex1, hex2 and hex5.
module score_display #(
    parameter int SCORE_W = 7,
    parameter int LEVEL_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SCORE_W-1:0] score,
    input  logic [LEVEL_W-1:0] level,
    input  logic               game_over,
    output logic [6:0]         hex0,
    output logic [6:0]         hex1,
    output logic [6:0]         hex2,
    output logic [6:0]         hex3,
    output logic [6:0]         hex4,
    output logic [6:0]         hex5,
    output logic [SCORE_W-1:0] high_score,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [3:0] LAST_CNT  = 4'(SCORE_W - 1);
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LEAD_RST  = SEG_BLANK;
`else
    localparam logic [6:0] LEAD_RST  = SEG_ZERO;
`endif

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = 7'b1111111;
        endcase
        return p;
    endfunction

    // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
    function automatic logic [11:0] bcd_adjust(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int i = 0; i < 3; i++) begin
            if (r[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
            end else begin
                r[i*4 +: 4] = r[i*4 +: 4];
            end
        end
        return r;
    endfunction

    state_t               state_q, state_d;
    logic [SCORE_W-1:0]   bin_q, bin_d;
    logic [SCORE_W-1:0]   val_q, val_d;
    logic [SCORE_W-1:0]   last_src_q, last_src_d;
    logic [11:0]          bcd_q, bcd_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [6:0]           hex0_q, hex0_d, hex1_q, hex1_d, hex2_q, hex2_d;
    logic [6:0]           hex4_q, hex4_d, hex5_q, hex5_d;
    logic [SCORE_W-1:0]   high_score_q, high_score_d;
    logic                 go_q;
    logic                 busy_q;
    logic [SCORE_W-1:0]   src_s;
    logic [11:0]          adj_s;
    logic [3:0]           units_s, tens_s, hund_s;
    logic [3:0]           lvl_s, lvl_units_s;
    logic                 lvl_tens_s;

    // Conversion source selection and BCD digit split.
    always_comb begin
        src_s   = game_over ? high_score_q : score;
        adj_s   = bcd_adjust(bcd_q);
        units_s = bcd_q[3:0];
        tens_s  = bcd_q[7:4];
        hund_s  = bcd_q[11:8];
    end

    // Conversion FSM next-state and datapath.
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        val_d      = val_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        last_src_d = last_src_q;
        hex0_d     = hex0_q;
        hex1_d     = hex1_q;
        hex2_d     = hex2_q;
        case (state_q)
            IDLE: begin
                if (src_s != last_src_q) begin
                    state_d = SHIFT;
                    bin_d   = src_s;
                    val_d   = src_s;
                    bcd_d   = 12'd0;
                    cnt_d   = 4'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                bcd_d = (adj_s << 1) | {11'd0, bin_q[SCORE_W-1]};
                bin_d = bin_q << 1;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                hex0_d = seg_decode(units_s);
`ifdef LEADING_ZERO_BLANK_EN
                hex2_d = (hund_s == 4'd0) ? SEG_BLANK : seg_decode(hund_s);
                hex1_d = ((hund_s == 4'd0) && (tens_s == 4'd0)) ? SEG_BLANK : seg_decode(tens_s);
`else
                hex2_d = seg_decode(hund_s);
                hex1_d = seg_decode(tens_s);
`endif
                last_src_d = val_q;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Level decode into units/tens displays.
    always_comb begin
        lvl_s = 4'(level);
        if (lvl_s >= 4'd10) begin
            lvl_units_s = lvl_s - 4'd10;
            lvl_tens_s  = 1'b1;
        end else begin
            lvl_units_s = lvl_s;
            lvl_tens_s  = 1'b0;
        end
        hex4_d = seg_decode(lvl_units_s);
`ifdef LEADING_ZERO_BLANK_EN
        hex5_d = lvl_tens_s ? seg_decode(4'd1) : SEG_BLANK;
`else
        hex5_d = lvl_tens_s ? seg_decode(4'd1) : SEG_ZERO;
`endif
    end

    // High score captures a better score on the rising edge of game_over.
    always_comb begin
        if (game_over && !go_q && (score > high_score_q)) begin
            high_score_d = score;
        end else begin
            high_score_d = high_score_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            bin_q        <= '0;
            val_q        <= '0;
            last_src_q   <= '0;
            bcd_q        <= 12'd0;
            cnt_q        <= 4'd0;
            hex0_q       <= SEG_ZERO;
            hex1_q       <= LEAD_RST;
            hex2_q       <= LEAD_RST;
            hex4_q       <= SEG_ZERO;
            hex5_q       <= LEAD_RST;
            high_score_q <= '0;
            go_q         <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bin_q        <= bin_d;
            val_q        <= val_d;
            last_src_q   <= last_src_d;
            bcd_q        <= bcd_d;
            cnt_q        <= cnt_d;
            hex0_q       <= hex0_d;
            hex1_q       <= hex1_d;
            hex2_q       <= hex2_d;
            hex4_q       <= hex4_d;
            hex5_q       <= hex5_d;
            high_score_q <= high_score_d;
            go_q         <= game_over;
            busy_q       <= (state_d != IDLE);
        end
    end

    assign hex0       = hex0_q;
    assign hex1       = hex1_q;
    assign hex2       = hex2_q;
    assign hex3       = SEG_BLANK;
    assign hex4       = hex4_q;
    assign hex5       = hex5_q;
    assign high_score = high_score_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_score_display.sv
// Randomized scoreboard bench for score_display; expected displays come from decimal arithmetic on the score.
module tb_score_display;

    localparam int SCORE_W = 7;
    localparam int LEVEL_W = 4;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] SEG_TAB [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                            7'b0000000, 7'b0010000};

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [SCORE_W-1:0] score = '0;
    logic [LEVEL_W-1:0] level = '0;
    logic               game_over = 1'b0;
    logic [6:0]         hex0, hex1, hex2, hex3, hex4, hex5;
    logic [SCORE_W-1:0] high_score;
    logic               busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int exp_val_q[$];
    int exp_due_q[$];
    int m_hs = 0, m_last = 0, m_free = 0, m_start = 0, m_lvl = 0;
    bit m_active = 1'b0, m_go_prev = 1'b0, exp_busy = 1'b0;

    score_display #(.SCORE_W(SCORE_W), .LEVEL_W(LEVEL_W)) dut (
        .clk(clk), .reset(reset), .score(score), .level(level), .game_over(game_over),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
        .high_score(high_score), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [20:0] disp_pat(input int v);
        logic [6:0] p2, p1, p0;
        p0 = SEG_TAB[v % 10];
        p1 = SEG_TAB[(v / 10) % 10];
        p2 = SEG_TAB[v / 100];
`ifdef LEADING_ZERO_BLANK_EN
        if (v < 100) p2 = BLANK;
        if (v < 10)  p1 = BLANK;
`endif
        return {p2, p1, p0};
    endfunction

    function automatic logic [13:0] lvl_pat(input int l);
        logic [6:0] p5, p4;
        p4 = SEG_TAB[l % 10];
        p5 = SEG_TAB[l / 10];
`ifdef LEADING_ZERO_BLANK_EN
        if (l < 10) p5 = BLANK;
`endif
        return {p5, p4};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Reference model: a new conversion starts whenever the display path is free and the source differs.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                m_hs = 0; m_last = 0; m_go_prev = 1'b0; m_free = 0;
                m_active = 1'b0; m_lvl = 0; exp_busy = 1'b0;
                exp_val_q.delete();
                exp_due_q.delete();
            end else begin
                int src;
                src = game_over ? m_hs : int'(score);
                if (cyc >= m_free && src != m_last) begin
                    exp_val_q.push_back(src);
                    exp_due_q.push_back(cyc + SCORE_W + 1);
                    m_last   = src;
                    m_free   = cyc + SCORE_W + 2;
                    m_start  = cyc;
                    m_active = 1'b1;
                end
                exp_busy = m_active && (cyc <= m_start + SCORE_W);
                if (game_over && !m_go_prev && int'(score) > m_hs) m_hs = int'(score);
                m_go_prev = game_over;
                m_lvl = int'(level);
            end
        end
    end

    // Monitor: pops an expected value whenever busy drops and checks all outputs every cycle.
    initial begin
        logic [20:0] disp;
        bit busy_prev;
        disp = disp_pat(0);
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_high_score", 32'(high_score), 32'd0);
                check("rst_display", 32'({hex2, hex1, hex0}), 32'(disp_pat(0)));
                check("rst_level", 32'({hex5, hex4}), 32'(lvl_pat(0)));
                check("rst_hex3", 32'(hex3), 32'(BLANK));
                disp = disp_pat(0);
                busy_prev = 1'b0;
            end else begin
                if (busy_prev && !busy) begin
                    if (exp_val_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: conversion ended with none expected (cycle %0d)", cyc);
                    end else begin
                        int v, d;
                        v = exp_val_q.pop_front();
                        d = exp_due_q.pop_front();
                        check("done_cycle", 32'(cyc), 32'(d));
                        disp = disp_pat(v);
                    end
                end
                check("display", 32'({hex2, hex1, hex0}), 32'(disp));
                check("busy", 32'(busy), 32'(exp_busy));
                check("high_score", 32'(high_score), 32'(m_hs));
                check("level", 32'({hex5, hex4}), 32'(lvl_pat(m_lvl)));
                check("hex3", 32'(hex3), 32'(BLANK));
                busy_prev = busy;
            end
        end
    end

    initial begin
        step(3);
        reset = 1'b0;
        step(3);
        score = 7'd123;                 step(12);
        score = 7'd45;                  step(3);
        score = 7'd46;                  step(25);
        level = 4'd12;                  step(2);
        level = 4'd7;                   step(2);
        score = 7'd20;                  step(12);
        game_over = 1'b1;               step(12);
        game_over = 1'b0; score = 7'd37; step(12);
        game_over = 1'b1;               step(30);
        game_over = 1'b0; score = 7'd12; step(12);
        game_over = 1'b1;               step(30);
        game_over = 1'b0;               step(12);
        score = 7'd99;                  step(5);
        reset = 1'b1;                   step(1);
        reset = 1'b0;                   step(15);
        for (int i = 0; i < 700; i++) begin
            step(1);
            reset = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 5) == 0) score = SCORE_W'($urandom_range(0, 127));
            if ($urandom_range(0, 3) == 0) level = LEVEL_W'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) game_over = ~game_over;
        end
        step(1);
        reset = 1'b0;
        game_over = 1'b0;
        for (int i = 0; i < 60 && (busy || exp_val_q.size() != 0); i++) step(1);
        check("drain", 32'(exp_val_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
